aircon_run_controller: RTL
==========================

// Module: aircon_run_controller
// PURPOSE
//   Downstream consumer of the airconditioner settings registers (temp, fan, timer).
//   Turns stored settings into actuator drive:
//   - compressor on/off with hysteresis and a minimum-off lockout;
//   - fan PWM;
//   - a sleep timer that counts down in minutes and shuts the unit off at zero.
//   Sits between the settings memories and the power stage.
// PARAMETERS
//   TICKS_PER_MIN  6000  clk cycles per timer minute (>=2)
//   HYST           1     degrees above setpoint required to start cooling (0..3)
//   LOCKOUT_TICKS  600   min clk cycles compressor stays off after stopping (>=1)
// PORTS
//   clk        in   1  single clock; all state on rising edge
//   rst        in   1  asynchronous, active-high reset
//   pwr        in   1  power switch level (same signal as settings block power)
//   set_temp   in   5  setpoint, unsigned degrees (from temp register)
//   fan_lvl    in   5  fan level; only [2:0] used, 0..7
//   timer_min  in   5  sleep minutes; 0 = timer disabled
//   timer_ld   in   1  1-cycle pulse: load timer_min into countdown
//   room_temp  in   5  measured room temperature, unsigned degrees
//   comp_on    out  1  compressor drive
//   fan_pwm    out  1  fan PWM drive
//   run        out  1  unit running (power latched and timer not expired)
//   timer_left out  5  minutes remaining; 0 when disabled/expired
//   auto_off   out  1  1-cycle pulse when sleep timer expires
// BEHAVIOUR
//   Reset: all outputs 0; FSM=OFF; prescaler, pwm counter, lockout counter = 0.
//   run latch: set on pwr rising edge (pwr registered once for edge detect);
//     cleared on pwr low or timer expiry; after expiry stays 0 until next pwr rise.
//   Timer:
//   - timer_ld loads timer_left<=timer_min and clears the prescaler; ignored when run=0.
//   - While run and timer_left!=0: prescaler counts 0..TICKS_PER_MIN-1 and wraps.
//     On wrap, timer_left decrements.
//   - 1->0 decrement: auto_off=1 for exactly that cycle; run<=0 the same edge.
//   - timer_ld on the wrap cycle: load wins, no decrement.
//   - run falling: timer_left<=0.
//   FSM states: OFF, FAN_ONLY, COOLING (comp_on=1 only in COOLING, registered).
//   - OFF -> FAN_ONLY when run=1.
//   - FAN_ONLY -> COOLING when {1'b0,room_temp} > {1'b0,set_temp}+HYST (6-bit compare)
//     and lockout==0.
//   - COOLING -> FAN_ONLY when room_temp <= set_temp; lockout<=LOCKOUT_TICKS.
//   - any -> OFF when run=0; leaving COOLING this way also loads lockout.
//   - lockout decrements to 0 in every state, including OFF.
//   - Band set_temp < room_temp <= set_temp+HYST: hold current state.
//   Fan PWM:
//   - 3-bit free-running pwm_cnt, counts only while run=1.
//   - fan_pwm = run && (pwm_cnt < eff).
//   - eff = fan_lvl[2:0], forced to >=1 while COOLING.
//   - Level 0 in FAN_ONLY gives fan off; level 7 gives 7/8 duty.
//   Latency: input change -> comp_on/FSM in 1 cycle; pwr rise -> run in 2 cycles.
//   Mid-operation rst: immediate async clear of everything, including lockout.
// STRUCTURE
//   aircon_pkg:
//   - state enum localparams (OFF=2'd0, FAN_ONLY=2'd1, COOLING=2'd2);
//   - widths TEMP_W=5, FAN_W=3, TIMER_W=5.
//   Sub-module aircon_minute_timer:
//   - prescaler + countdown + auto_off;
//   - ports clk, rst, run, timer_ld, timer_min, timer_left, auto_off.
//   FSM, lockout and PWM stay in the top.
// TESTING (TICKS_PER_MIN=10, LOCKOUT_TICKS=20, HYST=1)
//   1. rst mid-COOLING -> comp_on, fan_pwm, run, timer_left, lockout all 0
//      asynchronously; recovery from pwr rise.
//   2. pwr 0->1, set_temp=20, room_temp=22 -> run at +2, COOLING at +3.
//      room_temp=20 -> FAN_ONLY. room_temp=22 again -> comp stays 0 for 20 cycles.
//   3. room_temp=21, set_temp=20 from FAN_ONLY -> no cooling (band).
//      Same value entered while COOLING -> cooling holds.
//   4. timer_min=2, timer_ld -> timer_left 2,1,0 at 10-cycle intervals.
//      auto_off single pulse, run=0, comp_on=0.
//      pwr held high -> stays off; pwr 0->1 restarts.
//   5. fan_lvl=3 -> fan_pwm high 3 of every 8 cycles.
//      fan_lvl=0 -> 0 in FAN_ONLY, 1/8 duty in COOLING. fan_lvl=7 -> 7/8 duty.
//   6. timer_ld on the same cycle as a prescaler wrap -> reload value,
//      no extra decrement.

Source files
------------

// File: rtl/aircon_pkg.sv
// Shared widths, FSM state encoding and small comparison helpers for the
// air-conditioner run controller.
package aircon_pkg;

    localparam int TEMP_W  = 5;
    localparam int FAN_W   = 3;
    localparam int TIMER_W = 5;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        FAN_ONLY = 2'd1,
        COOLING  = 2'd2
    } state_t;

    // Widened to 6 bits so set_temp + hyst cannot wrap near the top of the range.
    function automatic logic above_band(input logic [TEMP_W-1:0] room,
                                        input logic [TEMP_W-1:0] set,
                                        input logic [1:0]        hyst);
        return ({1'b0, room} > ({1'b0, set} + {4'b0000, hyst}));
    endfunction

    // While cooling the fan must never stop, so level 0 is lifted to 1.
    function automatic logic [FAN_W-1:0] eff_level(input logic [FAN_W-1:0] lvl,
                                                   input logic             cooling);
        return (cooling && (lvl == '0)) ? FAN_W'(1) : lvl;
    endfunction

endpackage

// File: rtl/aircon_run_controller_if.sv
// Settings-in / actuator-out bundle between the settings block, the run
// controller and the power stage.
interface aircon_run_controller_if;
    import aircon_pkg::*;

    logic               pwr;
    logic [TEMP_W-1:0]  set_temp;
    logic [4:0]         fan_lvl;
    logic [TIMER_W-1:0] timer_min;
    logic               timer_ld;
    logic [TEMP_W-1:0]  room_temp;
    logic               comp_on;
    logic               fan_pwm;
    logic               run;
    logic [TIMER_W-1:0] timer_left;
    logic               auto_off;

    modport master (
        output pwr, set_temp, fan_lvl, timer_min, timer_ld, room_temp,
        input  comp_on, fan_pwm, run, timer_left, auto_off
    );

    modport slave (
        input  pwr, set_temp, fan_lvl, timer_min, timer_ld, room_temp,
        output comp_on, fan_pwm, run, timer_left, auto_off
    );

endinterface

// File: rtl/aircon_minute_timer.sv
// Sleep timer: minute prescaler plus countdown; pulses auto_off and flags
// the expiring edge so the run latch can drop on that same edge.
module aircon_minute_timer
    import aircon_pkg::*;
#(
    parameter int TICKS_PER_MIN = 6000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               timer_ld,
    input  logic [TIMER_W-1:0] timer_min,
    output logic [TIMER_W-1:0] timer_left,
    output logic               auto_off,
    output logic               expire
);

    localparam int            PW   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_MIN - 1);

    logic [PW-1:0]      r_presc;
    logic [TIMER_W-1:0] r_left;
    logic               r_auto_off;
    logic               w_wrap;

    assign w_wrap = (r_presc == LAST);
    // A load on the wrap cycle takes priority, so it suppresses expiry too.
    assign expire = run && !timer_ld && (r_left == TIMER_W'(1)) && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_left     <= '0;
            r_auto_off <= 1'b0;
        end else begin
            r_auto_off <= 1'b0;
            if (!run) begin
                r_presc <= '0;
                r_left  <= '0;
            end else if (timer_ld) begin
                r_presc <= '0;
                r_left  <= timer_min;
            end else if (r_left != '0) begin
                if (w_wrap) begin
                    r_presc    <= '0;
                    r_left     <= r_left - TIMER_W'(1);
                    r_auto_off <= (r_left == TIMER_W'(1));
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign timer_left = r_left;
    assign auto_off   = r_auto_off;

endmodule

// File: rtl/aircon_run_controller.sv
// Run controller: power latch, compressor FSM with hysteresis and restart
// lockout, fan PWM, and the sleep timer.
module aircon_run_controller
    import aircon_pkg::*;
#(
    parameter int TICKS_PER_MIN = 6000,
    parameter int HYST          = 1,
    parameter int LOCKOUT_TICKS = 600
) (
    input  logic                    clk,
    input  logic                    rst,
    aircon_run_controller_if.slave  bus
);

    localparam int            LW        = $clog2(LOCKOUT_TICKS + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_TICKS);

    logic             r_pwr_s;
    logic             r_pwr_d;
    logic             r_run;
    state_t           r_state;
    logic             r_comp_on;
    logic [LW-1:0]    r_lockout;
    logic [FAN_W-1:0] r_pwm_cnt;

    logic             w_pwr_rise;
    logic             w_expire;
    logic             w_hot;
    logic             w_cool_done;
    logic [FAN_W-1:0] w_eff;
    logic             w_unused_fan_hi;

    assign w_pwr_rise      = r_pwr_s && !r_pwr_d;
    assign w_hot           = above_band(bus.room_temp, bus.set_temp, 2'(HYST));
    assign w_cool_done     = (bus.room_temp <= bus.set_temp);
    assign w_eff           = eff_level(bus.fan_lvl[FAN_W-1:0], r_state == COOLING);
    assign w_unused_fan_hi = |bus.fan_lvl[4:FAN_W];

    aircon_minute_timer #(
        .TICKS_PER_MIN (TICKS_PER_MIN)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (r_run),
        .timer_ld   (bus.timer_ld),
        .timer_min  (bus.timer_min),
        .timer_left (bus.timer_left),
        .auto_off   (bus.auto_off),
        .expire     (w_expire)
    );

    // After expiry the latch stays clear until a fresh rising edge of pwr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwr_s <= 1'b0;
            r_pwr_d <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_pwr_s <= bus.pwr;
            r_pwr_d <= r_pwr_s;
            if (!r_pwr_s || w_expire) begin
                r_run <= 1'b0;
            end else if (w_pwr_rise) begin
                r_run <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= OFF;
            r_comp_on <= 1'b0;
            r_lockout <= '0;
        end else begin
            if (r_lockout != '0) begin
                r_lockout <= r_lockout - LW'(1);
            end
            case (r_state)
                OFF: begin
                    r_comp_on <= 1'b0;
                    if (r_run) begin
                        r_state <= FAN_ONLY;
                    end
                end
                FAN_ONLY: begin
                    if (!r_run) begin
                        r_state <= OFF;
                    end else if (w_hot && (r_lockout == '0)) begin
                        r_state   <= COOLING;
                        r_comp_on <= 1'b1;
                    end
                end
                COOLING: begin
                    // Any exit from cooling arms the restart lockout.
                    if (!r_run || w_cool_done) begin
                        r_state   <= r_run ? FAN_ONLY : OFF;
                        r_comp_on <= 1'b0;
                        r_lockout <= LOCK_LOAD;
                    end
                end
                default: begin
                    r_state   <= OFF;
                    r_comp_on <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (r_run) begin
            r_pwm_cnt <= r_pwm_cnt + FAN_W'(1);
        end
    end

    assign bus.comp_on = r_comp_on;
    assign bus.run     = r_run;
    assign bus.fan_pwm = r_run && (r_pwm_cnt < w_eff);

endmodule
